// File: rtl/cmp_pipe_stream.sv
// ---------------------------------------------------------------------------
// cmp_pipe_stream
//
// Purpose:
//   Two-stage pipelined magnitude comparator with a valid/ready stream on both
//   sides. Each transaction carries two WIDTH-bit operands and a signed/unsigned
//   selector. Each delivered result is a one-hot lt/eq/gt flag triple.
//   Saturating per-result event counters tally every delivered result.
//
// Parameters:
//   WIDTH     operand width in bits (>= 2)
//   CNT_W     width of each result counter (>= 2)
//   SIGNED_EN 1: in_signed selects two's-complement compare, 0: always unsigned
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   producer offers a transaction
//   in_ready   block can take a transaction this cycle
//   in_a/in_b  operands
//   in_signed  1 = compare as two's-complement (when SIGNED_EN = 1)
//   out_valid  a result is presented
//   out_ready  consumer takes the presented result
//   out_lt/eq/gt one-hot result flags, all zero when out_valid = 0
//   cnt_clr    synchronous clear of all counters (wins over a same-cycle count)
//   cnt_lt/eq/gt saturating counts of delivered results
// ---------------------------------------------------------------------------
module cmp_pipe_stream #(
   parameter int WIDTH     = 8,
   parameter int CNT_W     = 16,
   parameter bit SIGNED_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_signed,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_lt,
   output logic             out_eq,
   output logic             out_gt,
   input  logic             cnt_clr,
   output logic [CNT_W-1:0] cnt_lt,
   output logic [CNT_W-1:0] cnt_eq,
   output logic [CNT_W-1:0] cnt_gt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   // Stage 1: captured operands and the effective compare mode
   logic             s1_valid;
   logic [WIDTH-1:0] s1_a;
   logic [WIDTH-1:0] s1_b;
   logic             s1_signed;

   // Stage 2: result flags presented on the output
   logic             s2_valid;
   logic             s2_lt;
   logic             s2_eq;
   logic             s2_gt;

   // Flow control and handshake strobes
   logic             s2_adv;
   logic             s1_adv;
   logic             accept;
   logic             out_fire;

   // Order-preserving keys and the combinational compare result of stage 1
   logic [WIDTH-1:0] key_a;
   logic [WIDTH-1:0] key_b;
   logic             cmp_lt;
   logic             cmp_eq;
   logic             cmp_gt;

   // Stage 2 can take new data when it is empty or its result leaves this
   // cycle. Stage 1 can take new data when it is empty or it moves on to
   // stage 2. in_ready depends on out_ready and on state only, never on
   // in_valid. It is also forced low while reset is held.
   always_comb begin
      s2_adv   = ~s2_valid | out_ready;
      s1_adv   = s1_valid & s2_adv;
      in_ready = ~rst & (~s1_valid | s2_adv);
      accept   = in_valid & in_ready;
      out_fire = s2_valid & out_ready;
   end

   // Inverting the sign bit in signed mode maps two's-complement order onto
   // unsigned order. A single unsigned comparator then covers both modes.
   always_comb begin
      key_a  = {s1_a[WIDTH-1] ^ s1_signed, s1_a[WIDTH-2:0]};
      key_b  = {s1_b[WIDTH-1] ^ s1_signed, s1_b[WIDTH-2:0]};
      cmp_lt = key_a < key_b;
      cmp_eq = key_a == key_b;
      cmp_gt = key_a > key_b;
   end

   // Stage 1 register. Operands only load on an accepted transaction.
   // The mode is frozen at accept time with SIGNED_EN already applied.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid  <= 1'b0;
         s1_a      <= '0;
         s1_b      <= '0;
         s1_signed <= 1'b0;
      end else begin
         if (accept) begin
            s1_valid  <= 1'b1;
            s1_a      <= in_a;
            s1_b      <= in_b;
            s1_signed <= in_signed & SIGNED_EN;
         end else if (s1_adv) begin
            s1_valid  <= 1'b0;
         end
      end
   end

   // Stage 2 register. It holds while a result is stalled, which keeps the
   // flags stable under backpressure. Bubbles load all-zero flags, so the
   // outputs need no gating against out_valid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid <= 1'b0;
         s2_lt    <= 1'b0;
         s2_eq    <= 1'b0;
         s2_gt    <= 1'b0;
      end else if (s2_adv) begin
         s2_valid <= s1_valid;
         s2_lt    <= s1_valid & cmp_lt;
         s2_eq    <= s1_valid & cmp_eq;
         s2_gt    <= s1_valid & cmp_gt;
      end
   end

   always_comb begin
      out_valid = s2_valid;
      out_lt    = s2_lt;
      out_eq    = s2_eq;
      out_gt    = s2_gt;
   end

   // Result counters. A clear beats a same-cycle delivery, so a result
   // delivered during cnt_clr is not counted. Each counter sticks at
   // all-ones instead of wrapping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_lt <= '0;
         cnt_eq <= '0;
         cnt_gt <= '0;
      end else if (cnt_clr) begin
         cnt_lt <= '0;
         cnt_eq <= '0;
         cnt_gt <= '0;
      end else if (out_fire) begin
         if (s2_lt && (cnt_lt != CNT_MAX)) cnt_lt <= cnt_lt + CNT_ONE;
         if (s2_eq && (cnt_eq != CNT_MAX)) cnt_eq <= cnt_eq + CNT_ONE;
         if (s2_gt && (cnt_gt != CNT_MAX)) cnt_gt <= cnt_gt + CNT_ONE;
      end
   end

endmodule

// File: tb/tb_cmp_pipe_stream.sv
// ---------------------------------------------------------------------------
// tb_cmp_pipe_stream
//
// Purpose:
//   Self-checking bench for cmp_pipe_stream. Three instances share one
//   stimulus:
//     dut0  WIDTH=8, CNT_W=16, SIGNED_EN=1 (fully scoreboarded)
//     dut1  WIDTH=8, CNT_W=16, SIGNED_EN=0 (signed mode disabled)
//     dut2  WIDTH=8, CNT_W=4,  SIGNED_EN=1 (narrow counters, saturation)
// ---------------------------------------------------------------------------
module tb_cmp_pipe_stream;

   localparam int W     = 8;
   localparam int CMAX0 = 65535;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic         in_signed;
   logic         out_ready;
   logic         cnt_clr;

   logic         rdy0, vld0, lt0, eq0, gt0;
   logic [15:0]  clt0, ceq0, cgt0;
   logic         rdy1, vld1, lt1, eq1, gt1;
   logic [15:0]  clt1, ceq1, cgt1;
   logic         rdy2, vld2, lt2, eq2, gt2;
   logic [3:0]   clt2, ceq2, cgt2;

   int n_vec = 0;
   int n_err = 0;

   // Reference model state for dut0: the expected result for each transaction
   // in flight, in order, plus counter values built from delivered results
   logic [2:0] exp_q[$];
   int m_lt = 0;
   int m_eq = 0;
   int m_gt = 0;
   int delivered = 0;

   always #5 clk = ~clk;

   cmp_pipe_stream #(.WIDTH(W), .CNT_W(16), .SIGNED_EN(1'b1)) dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0),
      .in_a(in_a), .in_b(in_b), .in_signed(in_signed),
      .out_valid(vld0), .out_ready(out_ready),
      .out_lt(lt0), .out_eq(eq0), .out_gt(gt0),
      .cnt_clr(cnt_clr), .cnt_lt(clt0), .cnt_eq(ceq0), .cnt_gt(cgt0));

   cmp_pipe_stream #(.WIDTH(W), .CNT_W(16), .SIGNED_EN(1'b0)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1),
      .in_a(in_a), .in_b(in_b), .in_signed(in_signed),
      .out_valid(vld1), .out_ready(out_ready),
      .out_lt(lt1), .out_eq(eq1), .out_gt(gt1),
      .cnt_clr(cnt_clr), .cnt_lt(clt1), .cnt_eq(ceq1), .cnt_gt(cgt1));

   cmp_pipe_stream #(.WIDTH(W), .CNT_W(4), .SIGNED_EN(1'b1)) dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2),
      .in_a(in_a), .in_b(in_b), .in_signed(in_signed),
      .out_valid(vld2), .out_ready(out_ready),
      .out_lt(lt2), .out_eq(eq2), .out_gt(gt2),
      .cnt_clr(cnt_clr), .cnt_lt(clt2), .cnt_eq(ceq2), .cnt_gt(cgt2));

   // Single comparison point: bumps the counts and reports any difference
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      n_vec++;
      if (actual !== expected) begin
         n_err++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Expected {lt,eq,gt} from plain integer arithmetic on operand values
   function automatic logic [2:0] refFlags(input logic [W-1:0] a,
                                           input logic [W-1:0] b,
                                           input logic sg);
      int va;
      int vb;
      va = int'(a);
      vb = int'(b);
      if (sg && a[W-1]) va = va - (1 << W);
      if (sg && b[W-1]) vb = vb - (1 << W);
      if (va < vb)       return 3'b100;
      else if (va == vb) return 3'b010;
      else               return 3'b001;
   endfunction

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One isolated transaction with out_ready high, checking the exact
   // two-cycle latency and the flags of both dut0 and dut1
   task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic sg, input logic [2:0] e0,
                                input logic [2:0] e1, input string name);
      in_a      = a;
      in_b      = b;
      in_signed = sg;
      in_valid  = 1'b1;
      tick();
      in_valid  = 1'b0;
      checkOutput({name, "_lat1"}, vld0, 0);
      tick();
      checkOutput({name, "_vld"}, vld0, 1);
      checkOutput({name, "_d0"}, {lt0, eq0, gt0}, e0);
      checkOutput({name, "_d1"}, {lt1, eq1, gt1}, e1);
   endtask

   // Scoreboard for dut0, sampled on the falling edge. Checks come first,
   // then the model takes the handshakes the coming rising edge will perform.
   always @(negedge clk) begin : monitor
      logic [2:0] f;
      if (rst) begin
         exp_q.delete();
         m_lt = 0;
         m_eq = 0;
         m_gt = 0;
         checkOutput("rst_vld", vld0, 0);
         checkOutput("rst_rdy", rdy0, 0);
         checkOutput("rst_cnt", clt0 + ceq0 + cgt0, 0);
      end else begin
         if (vld0) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("[TB] FAIL stray_result: got flags %b, expected no output",
                        {lt0, eq0, gt0});
            end else begin
               checkOutput("flags", {lt0, eq0, gt0}, exp_q[0]);
            end
         end else begin
            checkOutput("idle_flags", {lt0, eq0, gt0}, 0);
         end
         checkOutput("cnt_lt", clt0, m_lt);
         checkOutput("cnt_eq", ceq0, m_eq);
         checkOutput("cnt_gt", cgt0, m_gt);
         f = 3'b000;
         if (vld0 && out_ready && exp_q.size() > 0) begin
            f = exp_q.pop_front();
            delivered++;
         end
         if (cnt_clr) begin
            m_lt = 0;
            m_eq = 0;
            m_gt = 0;
         end else begin
            if (f[2] && m_lt < CMAX0) m_lt++;
            if (f[1] && m_eq < CMAX0) m_eq++;
            if (f[0] && m_gt < CMAX0) m_gt++;
         end
         if (in_valid && rdy0) exp_q.push_back(refFlags(in_a, in_b, in_signed));
      end
   end

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         sg;
      logic [2:0]   e0;
      logic [2:0]   e1;
   } vec_t;

   vec_t tbl[8];

   initial begin : watchdog
      #200000;
      n_err++;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin : main
      logic [W-1:0] bpa[3];
      logic [W-1:0] bpb[3];
      int idx;
      int base;
      logic r;

      // {a, b, signed, dut0 flags, dut1 flags}, flags as {lt,eq,gt}
      tbl[0] = '{8'h05, 8'h03, 1'b0, 3'b001, 3'b001};
      tbl[1] = '{8'h03, 8'h03, 1'b0, 3'b010, 3'b010};
      tbl[2] = '{8'h00, 8'hFF, 1'b0, 3'b100, 3'b100};
      tbl[3] = '{8'hFF, 8'h01, 1'b1, 3'b100, 3'b001};
      tbl[4] = '{8'hFF, 8'h01, 1'b0, 3'b001, 3'b001};
      tbl[5] = '{8'h80, 8'h7F, 1'b1, 3'b100, 3'b001};
      tbl[6] = '{8'h7F, 8'h80, 1'b1, 3'b001, 3'b100};
      tbl[7] = '{8'h80, 8'h80, 1'b1, 3'b010, 3'b010};

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_signed = 1'b0;
      out_ready = 1'b1;
      cnt_clr   = 1'b0;

      // Reset state
      #1;
      checkOutput("reset_ready", rdy0, 0);
      checkOutput("reset_valid", vld0, 0);
      checkOutput("reset_cnt2", clt2 + ceq2 + cgt2, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #1 checkOutput("ready_after_release", rdy0, 1);

      // Directed compare vectors
      for (int i = 0; i < 8; i++)
         applyStimulus(tbl[i].a, tbl[i].b, tbl[i].sg, tbl[i].e0, tbl[i].e1,
                       $sformatf("vec%0d", i));
      tick();

      // Backpressure: three back-to-back offers against a stalled consumer
      bpa[0] = 8'd10; bpb[0] = 8'd20;
      bpa[1] = 8'd30; bpb[1] = 8'd30;
      bpa[2] = 8'd50; bpb[2] = 8'd40;
      base      = delivered;
      out_ready = 1'b0;
      in_signed = 1'b0;
      idx       = 0;
      for (int c = 0; c < 6; c++) begin
         in_valid = (idx < 3);
         in_a     = bpa[idx % 3];
         in_b     = bpb[idx % 3];
         #1 r = rdy0;
         tick();
         if (r && idx < 3) idx++;
      end
      checkOutput("bp_accepted", idx, 2);
      checkOutput("bp_ready_low", rdy0, 0);
      checkOutput("bp_valid", vld0, 1);
      for (int c = 0; c < 3; c++) begin
         tick();
         checkOutput("bp_hold_flags", {lt0, eq0, gt0}, 3'b100);
      end
      out_ready = 1'b1;
      for (int c = 0; c < 5; c++) begin
         in_valid = (idx < 3);
         #1 r = rdy0;
         tick();
         if (r && idx < 3) idx++;
      end
      in_valid = 1'b0;
      repeat (3) tick();
      checkOutput("bp_all_accepted", idx, 3);
      checkOutput("bp_delivered", delivered - base, 3);
      checkOutput("bp_queue_empty", exp_q.size(), 0);

      // Streaming: 100 random transactions at full rate
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      base = delivered;
      for (int i = 0; i < 100; i++) begin
         in_a      = W'($urandom);
         in_b      = (i % 4 == 0) ? in_a : W'($urandom);
         in_signed = 1'($urandom);
         in_valid  = 1'b1;
         #1 checkOutput("stream_ready", rdy0, 1);
         if (i >= 2) checkOutput("stream_valid", vld0, 1);
         tick();
      end
      in_valid = 1'b0;
      repeat (3) tick();
      checkOutput("stream_delivered", delivered - base, 100);
      checkOutput("stream_cnt_sum", clt0 + ceq0 + cgt0, 100);

      // Saturation of the 4-bit counters, then clear beating a handshake
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      for (int i = 0; i < 17; i++) begin
         in_a      = W'($urandom);
         in_b      = in_a;
         in_signed = 1'($urandom);
         in_valid  = 1'b1;
         tick();
      end
      in_valid = 1'b0;
      repeat (3) tick();
      checkOutput("sat_cnt_eq2", ceq2, 15);
      checkOutput("sat_cnt_lt2", clt2, 0);
      checkOutput("wide_cnt_eq0", ceq0, 17);
      in_a      = 8'd1;
      in_b      = 8'd2;
      in_signed = 1'b0;
      in_valid  = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      checkOutput("clr_hs_valid", vld2, 1);
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      checkOutput("clr_cnt2", clt2 + ceq2 + cgt2, 0);
      checkOutput("clr_cnt0", clt0 + ceq0 + cgt0, 0);
      checkOutput("clr_delivered", vld0, 0);

      // Reset with two transactions in flight
      for (int i = 0; i < 3; i++) begin
         in_a     = W'(i);
         in_b     = 8'd1;
         in_valid = 1'b1;
         tick();
      end
      in_valid = 1'b0;
      repeat (3) tick();
      checkOutput("pre_rst_cnt", clt0 + ceq0 + cgt0, 3);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_a      = 8'h40;
      in_b      = 8'h20;
      tick();
      in_a = 8'h10;
      tick();
      in_valid = 1'b0;
      checkOutput("inflight_valid", vld0, 1);
      #2 rst = 1'b1;
      #1;
      checkOutput("midrst_valid", vld0, 0);
      checkOutput("midrst_ready", rdy0, 0);
      checkOutput("midrst_cnt0", clt0 + ceq0 + cgt0, 0);
      checkOutput("midrst_cnt2", clt2 + ceq2 + cgt2, 0);
      @(posedge clk);
      #3 rst = 1'b0;
      #1 checkOutput("post_rst_ready", rdy0, 1);
      out_ready = 1'b1;
      for (int c = 0; c < 5; c++) begin
         tick();
         checkOutput("no_stale_result", vld0, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
